div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle RV32M divide/remainder unit, sitting directly upstream of the register file write port. It accepts two source operands already read from the register file plus a destination register number. It runs a radix-2 restoring division and drives a one-cycle write-enable/number/data triple straight into the register file's write port. The core stalls on `busy` while an operation is in flight.

## Interface
- `XLEN`, 32: operand/result width; counter width is clog2(XLEN)+1.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state and outputs immediately.
- `start` in 1: request a new operation; sampled only in IDLE.
- `kill` in 1: abort the in-flight operation (pipeline flush/trap).
- `op` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- `regNum` in 5: destination register, captured with `start`.
- `srcData0` in XLEN: dividend (rs1 value), captured with `start`.
- `srcData1` in XLEN: divisor (rs2 value), captured with `start`.
- `busy` out 1: high in CALC and DONE.
- `done` out 1: one-cycle pulse in DONE.
- `regsWriteEnable` out 1: write strobe to the register file, high in DONE when captured rd != 0.
- `regWriteNum` out 5: captured rd, valid while `done`.
- `regWriteData` out XLEN: final quotient or remainder, valid while `done`.

## Operation
- States: IDLE, CALC, DONE. After reset: IDLE, all outputs 0, `regWriteData` 0.
- IDLE and `start` and not `kill`:
  - capture op, rd and operands.
  - Signed ops: latch magnitudes, `qneg` = sign(a) XOR sign(b), `rneg` = sign(a).
  - Load counter = XLEN, then go to CALC.
- Special cases, resolved at capture. They go to DONE without CALC:
  - divisor 0: DIV/DIVU result all ones (0xFFFFFFFF); REM/REMU result = dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: result 0x80000000. REM with the same operands: result 0.
- CALC, one iteration per cycle:
  - shift {rem, quo} left 1.
  - trial = rem − divisor (XLEN+1 bits).
  - if trial non-negative: rem = trial, quo LSB = 1.
  - Decrement the counter; at 1, go to DONE.
- DONE:
  - regWriteData = quo or rem, negated (two's complement) per `qneg`/`rneg` for signed ops.
  - `done` = 1.
  - `regsWriteEnable` = (rd != 0).
  - Return to IDLE next cycle.
- `kill` in CALC: go to IDLE next cycle. No DONE, no write, `busy` drops.
- `kill` and `start` together in IDLE: nothing accepted. `kill` in DONE: ignored, since the write commits.
- `start` while `busy`: ignored; it is not queued.
- `reset` asserted in any state: immediate IDLE, all outputs 0. An in-flight result is discarded.

## Timing
- `start` sampled at edge E0 → CALC for edges E1..E32 → DONE is the cycle after E32 (outputs registered). Normal latency is 33 cycles from acceptance to the write cycle.
- Special case: DONE in the cycle after E0 (latency 1).
- `busy` rises the cycle after acceptance and falls the cycle after DONE. A new `start` can be accepted in the cycle `busy` is low, i.e. back-to-back with one idle cycle minimum.
- All outputs are registered, with no combinational path from inputs to outputs.
- The write triple is held stable for the whole DONE cycle, so the register file's falling-edge write captures it.

## Configuration
- `DIV_EARLY_OUT_EN` defined: at capture, if |divisor| > |dividend| (unsigned compare of magnitudes), go straight to DONE with quo = 0 and rem = dividend magnitude. Latency is 1 and sign rules still apply.
- Not defined: such operands take the full 32 CALC cycles and give identical results.
- Divide-by-zero and overflow shortcuts are present in both builds.

## Test plan
- DIVU 100 / 7 to rd=5 → after 33 cycles `done` pulse, `regsWriteEnable`=1, `regWriteNum`=5, `regWriteData`=14. REMU on the same operands → 2.
- DIV −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD (−3). REM on the same operands → 0xFFFFFFFF (−1).
- DIVU 5 / 0 → 0xFFFFFFFF at latency 1. REM 0x80000000 / 0xFFFFFFFF → 0. DIV on the same operands → 0x80000000.
- Operation to rd=0 → `done`=1, `regsWriteEnable`=0. `start` pulsed during CALC → ignored, and only one `done` is seen.
- `kill` at cycle 10 of CALC → `busy` low next cycle, no `done`. `reset` low mid-CALC → all outputs 0 immediately, and an operation started after release completes normally.
- 3 / 10 with `DIV_EARLY_OUT_EN` → result 0 (DIVU) or 3 (REMU) at latency 1. Without the macro → same values at latency 33.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit (radix-2 restoring) feeding the register file write port.
// Optional build macro DIV_EARLY_OUT_EN: finish immediately when |divisor| > |dividend|.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [4:0]      regNum,
  input  logic [XLEN-1:0] srcData0,
  input  logic [XLEN-1:0] srcData1,
  output logic            busy,
  output logic            done,
  output logic            regsWriteEnable,
  output logic [4:0]      regWriteNum,
  output logic [XLEN-1:0] regWriteData
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic            is_rem_q;
  logic            neg_q;
  logic [4:0]      rd_q;
  logic            busy_q;
  logic            done_q;
  logic            we_q;
  logic [4:0]      wnum_q;
  logic [XLEN-1:0] wdata_q;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + XLEN'(1)) : v;
  endfunction

  // Capture-time decode: magnitudes, result sign and the single-cycle shortcuts
  logic            signed_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [XLEN-1:0] a_mag_s;
  logic [XLEN-1:0] b_mag_s;
  logic            div_zero_s;
  logic            ovf_s;
  logic            early_s;
  logic            short_s;
  logic            neg_cap_s;
  logic [XLEN-1:0] short_res_s;

  always_comb begin
    signed_s    = ~op[0];
    a_neg_s     = signed_s & srcData0[XLEN-1];
    b_neg_s     = signed_s & srcData1[XLEN-1];
    a_mag_s     = cond_neg(srcData0, a_neg_s);
    b_mag_s     = cond_neg(srcData1, b_neg_s);
    div_zero_s  = (srcData1 == {XLEN{1'b0}});
    ovf_s       = signed_s && (srcData0 == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (srcData1 == {XLEN{1'b1}});
`ifdef DIV_EARLY_OUT_EN
    early_s     = (b_mag_s > a_mag_s);
`else
    early_s     = 1'b0;
`endif
    short_s     = div_zero_s | ovf_s | early_s;
    neg_cap_s   = op[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
    short_res_s = {XLEN{1'b0}};
    if (div_zero_s) begin
      short_res_s = op[1] ? srcData0 : {XLEN{1'b1}};
    end else if (ovf_s) begin
      short_res_s = op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end else begin
      // early-out: quotient 0, remainder keeps the dividend's sign and value
      short_res_s = op[1] ? srcData0 : {XLEN{1'b0}};
    end
  end

  // One restoring iteration plus the signed result it would produce
  logic [XLEN:0]   rem_sh_s;
  logic [XLEN:0]   trial_s;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;
  logic [XLEN-1:0] res_d;

  always_comb begin
    rem_sh_s = {rem_q, quo_q[XLEN-1]};
    trial_s  = rem_sh_s - {1'b0, dvs_q};
    if (!trial_s[XLEN]) begin
      rem_d = trial_s[XLEN-1:0];
    end else begin
      rem_d = rem_sh_s[XLEN-1:0];
    end
    quo_d = {quo_q[XLEN-2:0], ~trial_s[XLEN]};
    res_d = cond_neg(is_rem_q ? rem_d : quo_d, neg_q);
  end

  // Control FSM with registered write-port outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      rem_q    <= {XLEN{1'b0}};
      quo_q    <= {XLEN{1'b0}};
      dvs_q    <= {XLEN{1'b0}};
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
      rd_q     <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      wnum_q   <= 5'd0;
      wdata_q  <= {XLEN{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          we_q   <= 1'b0;
          if (start && !kill) begin
            is_rem_q <= op[1];
            neg_q    <= neg_cap_s;
            rd_q     <= regNum;
            rem_q    <= {XLEN{1'b0}};
            quo_q    <= a_mag_s;
            dvs_q    <= b_mag_s;
            cnt_q    <= CW'(XLEN);
            busy_q   <= 1'b1;
            if (short_s) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              we_q    <= (regNum != 5'd0);
              wnum_q  <= regNum;
              wdata_q <= short_res_s;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (kill) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              we_q    <= (rd_q != 5'd0);
              wnum_q  <= rd_q;
              wdata_q <= res_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign regsWriteEnable = we_q;
  assign regWriteNum     = wnum_q;
  assign regWriteData    = wdata_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: results, latency, kill, reset and start-while-busy.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [4:0]  regNum = 5'd0;
  logic [31:0] srcData0 = 32'd0;
  logic [31:0] srcData1 = 32'd0;
  logic        busy;
  logic        done;
  logic        regsWriteEnable;
  logic [4:0]  regWriteNum;
  logic [31:0] regWriteData;

  int pass_cnt = 0;
  int total_cnt = 0;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .op(op), .regNum(regNum),
    .srcData0(srcData0), .srcData1(srcData1), .busy(busy), .done(done),
    .regsWriteEnable(regsWriteEnable), .regWriteNum(regWriteNum), .regWriteData(regWriteData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; regNum = rd; srcData0 = a; srcData1 = b;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0; srcData0 = 32'hDEADBEEF; srcData1 = 32'h0BADF00D; regNum = 5'd31;
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, regWriteData, exp);
    check({tag, "_we"}, {31'd0, regsWriteEnable}, {31'd0, rd != 5'd0});
    check({tag, "_num"}, {27'd0, regWriteNum}, {27'd0, rd});
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_done_drop"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int ndone;
    logic [31:0] seen_data;
    logic [4:0]  seen_num;

    repeat (2) @(negedge clk);
    check("reset_outs", {busy, done, regsWriteEnable, regWriteNum, 24'd0}, 32'd0);
    check("reset_data", regWriteData, 32'd0);
    reset = 1'b1;

    run_op("divu_100_7", 2'b01, 5'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 2'b11, 5'd5, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_m7_2",   2'b00, 5'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem_m7_2",   2'b10, 5'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("div_20_m3",  2'b00, 5'd8, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 33);
    run_op("divu_5_0",   2'b01, 5'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("remu_5_0",   2'b11, 5'd4, 32'd5, 32'd0, 32'd5, 1);
    run_op("rem_ovf",    2'b10, 5'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    run_op("div_ovf",    2'b00, 5'd6, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("divu_rd0",   2'b01, 5'd0, 32'd100, 32'd7, 32'd14, 33);
`ifdef DIV_EARLY_OUT_EN
    run_op("divu_3_10",  2'b01, 5'd9, 32'd3, 32'd10, 32'd0, 1);
    run_op("remu_3_10",  2'b11, 5'd9, 32'd3, 32'd10, 32'd3, 1);
`else
    run_op("divu_3_10",  2'b01, 5'd9, 32'd3, 32'd10, 32'd0, 33);
    run_op("remu_3_10",  2'b11, 5'd9, 32'd3, 32'd10, 32'd3, 33);
`endif

    // start pulsed mid-CALC must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'b01; regNum = 5'd7; srcData0 = 32'd1000; srcData1 = 32'd10;
    @(posedge clk);
    ndone = 0; seen_data = 32'd0; seen_num = 5'd0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (i == 5) begin
        op = 2'b01; regNum = 5'd9; srcData0 = 32'd9; srcData1 = 32'd3;
      end
      if (done) begin
        ndone++;
        seen_data = regWriteData;
        seen_num = regWriteNum;
      end
    end
    check("busy_start_ndone", ndone, 32'd1);
    check("busy_start_data", seen_data, 32'd100);
    check("busy_start_num", {27'd0, seen_num}, 32'd7);

    // kill at CALC cycle 10
    @(negedge clk);
    start = 1'b1; op = 2'b01; regNum = 5'd5; srcData0 = 32'd100; srcData1 = 32'd7;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("kill_busy_before", {31'd0, busy}, 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy_after", {31'd0, busy}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || regsWriteEnable) ndone++;
    end
    check("kill_no_done", ndone, 32'd0);

    // kill together with start in IDLE accepts nothing
    @(negedge clk);
    start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_start_idle", {30'd0, busy, done}, 32'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; op = 2'b01; regNum = 5'd5; srcData0 = 32'd100; srcData1 = 32'd7;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    check("rst_mid_outs", {busy, done, regsWriteEnable, regWriteNum, 24'd0}, 32'd0);
    check("rst_mid_data", regWriteData, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("after_rst", 2'b11, 5'd12, 32'd1000, 32'd7, 32'd6, 33);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
